// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and default geometry/timing.
package mem_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_ADDR_W  = 9;
    localparam int DEFAULT_DEPTH   = 2 ** DEFAULT_ADDR_W;
    localparam int DEFAULT_LATENCY = 2;

    // Wait counter is wide enough for the largest legal LATENCY (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with one write enable and a registered, enabled read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: cleared by reset, otherwise holds until the next enabled read.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: latches a MAR/MDR request, waits LATENCY cycles,
// performs the access and completes with a four-phase done handshake.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [DATA_W-1:0] mdr_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              busy,
    output logic              err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               op_wr_q, op_wr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               arr_we_s;
    logic               arr_re_s;

    // Next-state, request latching and RAM strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        op_wr_d  = op_wr_q;
        done_d   = done_q;
        err_d    = err_q;
        arr_we_s = 1'b0;
        arr_re_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (read && write) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ACK;
                end else if (read || write) begin
                    addr_d  = mar_addr;
                    wdata_d = mdr_wdata;
                    op_wr_d = write;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    // Gating with reset keeps an aborted write out of the array.
                    arr_we_s = op_wr_q & reset;
                    arr_re_s = ~op_wr_q;
                    done_d   = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!read && !write) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            default: begin
                done_d  = 1'b0;
                err_d   = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counter, request latches and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            op_wr_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk_i   (clk),
        .rst_n_i (reset),
        .we_i    (arr_we_s),
        .re_i    (arr_re_s),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: read expectations are queued at request time
// from a reference memory and compared when done rises.
module tb_mem_responder;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          read;
    logic          write;
    logic [AW-1:0] mar_addr;
    logic [DW-1:0] mdr_wdata;
    logic [DW-1:0] mem_rdata;
    logic          done;
    logic          busy;
    logic          err;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rdata;
    logic [AW-1:0] rnd_addr [8];

    always #5 clk = ~clk;

    mem_responder #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .mar_addr  (mar_addr),
        .mdr_wdata (mdr_wdata),
        .mem_rdata (mem_rdata),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_err"},  32'(err),  32'd0);
        check_eq({tag, "_rdata"}, mem_rdata, last_rdata);
    endtask

    // One complete handshake; hold = extra cycles the request stays high in ACK.
    task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int hold);
        int cycles;
        logic [DW-1:0] e;
        read      = rd;
        write     = wr;
        mar_addr  = a;
        mdr_wdata = d;
        if (rd && !wr) exp_q.push_back(model[a]);
        tick();
        check_eq("busy_t0", 32'(busy), 32'd1);
        if (rd && wr) begin
            check_eq("err_set",  32'(err),  32'd1);
            check_eq("done_err", 32'(done), 32'd1);
        end else begin
            check_eq("err_clr", 32'(err), 32'd0);
            cycles = 0;
            while (!done && cycles < 40) begin
                check_eq("busy_wait", 32'(busy), 32'd1);
                mar_addr  = AW'($urandom);
                mdr_wdata = $urandom;
                tick();
                cycles++;
            end
            check_eq("latency", 32'(cycles), 32'(LAT));
            check_eq("busy_ack", 32'(busy), 32'd1);
            if (wr) begin
                model[a] = d;
                check_eq("rdata_after_wr", mem_rdata, last_rdata);
            end else if (exp_q.size() == 0) begin
                check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("rdata", mem_rdata, e);
                last_rdata = e;
            end
        end
        for (int i = 0; i < hold; i++) begin
            mar_addr = AW'($urandom);
            tick();
            check_eq("done_hold", 32'(done), 32'd1);
            check_eq("busy_hold", 32'(busy), 32'd1);
            check_eq("rdata_hold", mem_rdata, last_rdata);
        end
        read  = 1'b0;
        write = 1'b0;
        tick();
        check_idle("release");
    endtask

    initial begin
        reset      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        mar_addr   = '0;
        mdr_wdata  = '0;
        last_rdata = 32'h0;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b1;
        tick();
        check_idle("post_reset");

        // Prior value at 1FF, then the basic write/read pair.
        access(1'b0, 1'b1, 9'h1FF, 32'h0BADF00D, 0);
        access(1'b0, 1'b1, 9'h00A, 32'hDEADBEEF, 0);
        access(1'b1, 1'b0, 9'h00A, 32'h0, 0);
        access(1'b0, 1'b1, 9'h00B, 32'hABCD1234, 0);
        check_eq("rdata_after_wr_00B", mem_rdata, 32'hDEADBEEF);

        // Collision: error completion, no access.
        access(1'b1, 1'b1, 9'h00A, 32'hFFFFFFFF, 0);
        access(1'b1, 1'b0, 9'h00A, 32'h0, 0);

        // Reset on the would-be completing edge aborts the write.
        read      = 1'b0;
        write     = 1'b1;
        mar_addr  = 9'h1FF;
        mdr_wdata = 32'h12345678;
        tick();
        check_eq("abort_busy", 32'(busy), 32'd1);
        tick();
        check_eq("abort_done_pre", 32'(done), 32'd0);
        reset = 1'b0;
        write = 1'b0;
        tick();
        last_rdata = 32'h0;
        check_idle("abort");
        reset = 1'b1;
        tick();
        access(1'b1, 1'b0, 9'h1FF, 32'h0, 0);
        access(1'b1, 1'b0, 9'h00A, 32'h0, 0);

        // Request held high through ACK must not start a second transaction.
        access(1'b1, 1'b0, 9'h00B, 32'h0, 5);

        // Randomised writes then readback through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            rnd_addr[i] = AW'(9'h040 + 9'(i * 37));
            access(1'b0, 1'b1, rnd_addr[i], $urandom, 0);
        end
        for (int i = 7; i >= 0; i--) begin
            access(1'b1, 1'b0, rnd_addr[i], 32'h0, i % 3);
        end
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
